// File: rtl/st2bus.sv
// st2bus: packs ST-bit framed stream beats LSB-first into BUS-bit words with a valid/ready output.
// Optional ST2BUS_STATUS_EN appends a per-packet status word after the final data word.
module st2bus #(
    parameter int BUS            = 512,
    parameter int ST             = 8,
    parameter int NUM_ST_PER_BUS = 64,
    parameter int BW             = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ST-1:0]   st_data,
    input  logic            st_valid,
    input  logic            st_sop,
    input  logic            st_eop,
    output logic            st_ready,
    output logic [BUS-1:0]  bus_data,
    output logic            bus_en,
    input  logic            bus_ready,
    output logic            bus_last,
    output logic [BW-1:0]   bus_bytes,
    output logic [15:0]     pkt_cnt,
    output logic            err_sop,
    output logic            err_nosop
);
    localparam int IW = BW - 1;
    localparam int SW = $clog2(BUS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1
`ifdef ST2BUS_STATUS_EN
        , STAT = 2'd2
`endif
    } state_t;

    state_t          r_state;
    logic [BUS-1:0]  r_pack;
    logic [IW-1:0]   r_idx;
    logic [BUS-1:0]  r_bus_data;
    logic            r_bus_en;
    logic            r_bus_last;
    logic [BW-1:0]   r_bus_bytes;
    logic [15:0]     r_pkt_cnt;
    logic            r_err_sop;
    logic            r_err_nosop;

    logic            w_in_pkt;
    logic            w_restart;
    logic [IW-1:0]   w_idx;
    logic [SW-1:0]   w_lsb;
    logic [BUS-1:0]  w_word;
    logic            w_acc;
    logic            w_xfer;
    logic            w_issue;

`ifdef ST2BUS_STATUS_EN
    logic [15:0]     r_beats;
    logic            r_restarted;
    logic [15:0]     w_beats;

    // Per-packet beat count, saturating, restarting at 1 on every sop
    always_comb begin
        w_beats = r_beats;
        if (w_restart) begin
            w_beats = 16'd1;
        end else if (r_beats != 16'hFFFF) begin
            w_beats = r_beats + 16'd1;
        end else begin
            w_beats = r_beats;
        end
    end

    assign st_ready = (r_state != STAT) && (!r_bus_en || bus_ready);
`else
    assign st_ready = !r_bus_en || bus_ready;
`endif

    // Beat placement: a sop (or any beat outside FILL) starts a fresh word at index 0
    always_comb begin
        w_in_pkt  = (r_state == FILL) || st_sop;
        w_restart = (r_state != FILL) || st_sop;
        w_idx     = w_restart ? '0 : r_idx;
        w_lsb     = SW'(w_idx) * SW'(ST);
        w_word    = w_restart ? '0 : r_pack;
        w_word[w_lsb +: ST] = st_data;
        w_acc     = st_valid && st_ready;
        w_xfer    = r_bus_en && bus_ready;
        w_issue   = w_acc && w_in_pkt && (st_eop || (w_idx == IW'(NUM_ST_PER_BUS - 1)));
    end

    // Framing FSM, pack register and the one-entry output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pack      <= '0;
            r_idx       <= '0;
            r_bus_data  <= '0;
            r_bus_en    <= 1'b0;
            r_bus_last  <= 1'b0;
            r_bus_bytes <= '0;
            r_pkt_cnt   <= 16'd0;
            r_err_sop   <= 1'b0;
            r_err_nosop <= 1'b0;
`ifdef ST2BUS_STATUS_EN
            r_beats     <= 16'd0;
            r_restarted <= 1'b0;
`endif
        end else begin
            r_err_sop   <= 1'b0;
            r_err_nosop <= 1'b0;
            if (w_xfer) begin
                r_bus_en <= 1'b0;
            end
            case (r_state)
                IDLE, FILL: begin
                    if (w_acc && !w_in_pkt) begin
                        r_err_nosop <= 1'b1;
                    end else if (w_acc) begin
                        if ((r_state == FILL) && st_sop) begin
                            r_err_sop <= 1'b1;
                        end
                        if (w_issue) begin
                            r_bus_en    <= 1'b1;
                            r_bus_data  <= w_word;
                            r_bus_bytes <= BW'(w_idx) + BW'(1);
                            r_bus_last  <= st_eop;
                            r_pack      <= '0;
                            r_idx       <= '0;
                            if (st_eop) begin
                                r_pkt_cnt <= r_pkt_cnt + 16'd1;
`ifdef ST2BUS_STATUS_EN
                                r_bus_last <= 1'b0;
                                r_state    <= STAT;
`else
                                r_state    <= IDLE;
`endif
                            end else begin
                                r_state <= FILL;
                            end
                        end else begin
                            r_pack  <= w_word;
                            r_idx   <= w_idx + IW'(1);
                            r_state <= FILL;
                        end
`ifdef ST2BUS_STATUS_EN
                        r_beats <= w_beats;
                        if (st_sop) begin
                            r_restarted <= (r_state == FILL);
                        end
`endif
                    end
                end
`ifdef ST2BUS_STATUS_EN
                // Status word follows once the final data word has left
                STAT: begin
                    if (w_xfer) begin
                        r_bus_en    <= 1'b1;
                        r_bus_data  <= BUS'({r_restarted, r_pkt_cnt, r_beats});
                        r_bus_bytes <= '0;
                        r_bus_last  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus_data  = r_bus_data;
    assign bus_en    = r_bus_en;
    assign bus_last  = r_bus_last;
    assign bus_bytes = r_bus_bytes;
    assign pkt_cnt   = r_pkt_cnt;
    assign err_sop   = r_err_sop;
    assign err_nosop = r_err_nosop;

endmodule

// File: tb/tb_st2bus.sv
// Self-checking bench for st2bus (default build): directed test-plan steps plus random packets
// checked against a byte-queue packet model.
module tb_st2bus;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   st_data;
    logic         st_valid, st_sop, st_eop, st_ready;
    logic [511:0] bus_data;
    logic         bus_en, bus_ready, bus_last;
    logic [6:0]   bus_bytes;
    logic [15:0]  pkt_cnt;
    logic         err_sop, err_nosop;

    st2bus dut (
        .clk(clk), .rst_n(rst_n), .st_data(st_data), .st_valid(st_valid),
        .st_sop(st_sop), .st_eop(st_eop), .st_ready(st_ready), .bus_data(bus_data),
        .bus_en(bus_en), .bus_ready(bus_ready), .bus_last(bus_last), .bus_bytes(bus_bytes),
        .pkt_cnt(pkt_cnt), .err_sop(err_sop), .err_nosop(err_nosop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        int           bytes;
        logic         last;
    } word_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     rdy_mode = 0;      // 0: ready=1, 1: random, 2: ready=0
    int     gap_en = 0;
    int     stall_cnt = 0;
    int     nosop_pulses = 0;
    int     sop_pulses = 0;
    word_t  q[$];              // expected words, oldest first
    word_t  cap[$];            // words observed leaving the DUT
    logic [7:0] cur[$];        // beats of the word being assembled
    bit     m_in_pkt = 0;
    logic [15:0] m_pkt_cnt = 16'd0;
    logic   m_err_sop = 1'b0;
    logic   m_err_nosop = 1'b0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_beat(input logic [7:0] d, input logic s, input logic e);
        word_t w;
        if (s) begin
            if (m_in_pkt) m_err_sop = 1'b1;
            cur.delete();
            m_in_pkt = 1;
        end else if (!m_in_pkt) begin
            m_err_nosop = 1'b1;
            return;
        end
        cur.push_back(d);
        if (cur.size() == 64 || e) begin
            w.data = '0;
            foreach (cur[i]) w.data[i*8 +: 8] = cur[i];
            w.bytes = cur.size();
            w.last  = e;
            q.push_back(w);
            cur.delete();
            if (e) begin
                m_in_pkt = 0;
                m_pkt_cnt = m_pkt_cnt + 16'd1;
            end
        end
    endtask

    // One clock cycle: drive, compare against the model, then advance the model
    task automatic step(input logic v, input logic [7:0] d, input logic s, input logic e,
                        output logic acc);
        word_t w;
        st_valid = v; st_data = d; st_sop = s; st_eop = e;
        case (rdy_mode)
            0: bus_ready = 1'b1;
            1: bus_ready = 1'($urandom_range(0, 1));
            default: bus_ready = 1'b0;
        endcase
        #1;
        check("pkt_cnt", pkt_cnt, m_pkt_cnt);
        check("err_sop", err_sop, m_err_sop);
        check("err_nosop", err_nosop, m_err_nosop);
        check("bus_en", bus_en, q.size() != 0);
        check("st_ready", st_ready, (q.size() == 0) || bus_ready);
        if (err_sop) sop_pulses++;
        if (err_nosop) nosop_pulses++;
        if (bus_en && q.size() != 0) begin
            check("bus_data", bus_data, q[0].data);
            check("bus_bytes", bus_bytes, q[0].bytes);
            check("bus_last", bus_last, q[0].last);
        end
        m_err_sop = 1'b0;
        m_err_nosop = 1'b0;
        if (bus_en && bus_ready) begin
            w.data = bus_data; w.bytes = int'(bus_bytes); w.last = bus_last;
            cap.push_back(w);
            if (q.size() != 0) void'(q.pop_front());
        end
        acc = v && st_ready;
        if (acc) model_beat(d, s, e);
        @(negedge clk);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic s, input logic e);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            if (gap_en != 0 && $urandom_range(0, 3) == 0)
                step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), acc);
            step(1'b1, d, s, e, acc);
            if (!acc) stall_cnt++;
            n++;
        end
        if (!acc) check("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_pkt(input int len, input int restart_at, input bit idx_data);
        for (int i = 0; i < len; i++)
            send_beat(idx_data ? 8'(i) : 8'($urandom), (i == 0) || (i == restart_at), i == len - 1);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            step(1'b0, 8'd0, 1'b0, 1'b0, acc);
            n++;
        end
        step(1'b0, 8'd0, 1'b0, 1'b0, acc);
        if (q.size() != 0) check("drain_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        logic acc;
        rst_n = 1'b0; st_valid = 1'b0; st_data = 8'd0; st_sop = 1'b0; st_eop = 1'b0;
        bus_ready = 1'b0;
        #12;
        check("rst_bus_en", bus_en, 1'b0);
        check("rst_bus_data", bus_data, 512'd0);
        check("rst_bus_last", bus_last, 1'b0);
        check("rst_bus_bytes", bus_bytes, 7'd0);
        check("rst_pkt_cnt", pkt_cnt, 16'd0);
        check("rst_st_ready", st_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // 128-beat packet, full rate
        cap.delete(); stall_cnt = 0;
        send_pkt(128, -1, 1'b1);
        drain();
        check("t1_no_stall", stall_cnt, 0);
        check("t1_words", cap.size(), 2);
        if (cap.size() == 2) begin
            check("t1_w0_bytes", cap[0].bytes, 64);
            check("t1_w0_last", cap[0].last, 1'b0);
            check("t1_w0_b0", cap[0].data[7:0], 8'd0);
            check("t1_w0_b63", cap[0].data[511:504], 8'd63);
            check("t1_w1_last", cap[1].last, 1'b1);
            check("t1_w1_b0", cap[1].data[7:0], 8'd64);
            check("t1_w1_b63", cap[1].data[511:504], 8'd127);
        end
        check("t1_pkt_cnt", pkt_cnt, 16'd1);

        // 70-beat packet: short final word zero-padded
        cap.delete();
        send_pkt(70, -1, 1'b1);
        drain();
        if (cap.size() == 2) begin
            check("t2_bytes", cap[1].bytes, 6);
            check("t2_last", cap[1].last, 1'b1);
            check("t2_pad", cap[1].data >> 48, 512'd0);
        end else check("t2_words", cap.size(), 2);

        // Output stall for 10 cycles, then release and resume input
        send_pkt(64, -1, 1'b0);
        rdy_mode = 2;
        for (int i = 0; i < 10; i++) step(1'b1, 8'h11, 1'b1, 1'b0, acc);
        rdy_mode = 0;
        drain();
        send_pkt(3, -1, 1'b0);
        drain();

        // Beat without sop in IDLE, then sop restart at beat 30 of a 40-beat run
        nosop_pulses = 0; sop_pulses = 0; cap.delete();
        send_beat(8'h77, 1'b0, 1'b0);
        send_pkt(40, 30, 1'b1);
        drain();
        check("t4_nosop_pulses", nosop_pulses, 1);
        check("t4_sop_pulses", sop_pulses, 1);
        if (cap.size() == 1) begin
            check("t4_bytes", cap[0].bytes, 10);
            check("t4_first", cap[0].data[7:0], 8'd30);
        end else check("t4_words", cap.size(), 1);

        // Single-beat packet sop+eop
        cap.delete();
        send_beat(8'hA5, 1'b1, 1'b1);
        drain();
        if (cap.size() == 1) begin
            check("t5_data", cap[0].data, 512'hA5);
            check("t5_bytes", cap[0].bytes, 1);
            check("t5_last", cap[0].last, 1'b1);
        end else check("t5_words", cap.size(), 1);

        // Random packets, random gaps/backpressure, occasional restarts and stray beats
        rdy_mode = 1; gap_en = 1;
        for (int p = 0; p < 30; p++) begin
            if ($urandom_range(0, 9) == 0) send_beat(8'($urandom), 1'b0, $urandom_range(0, 1) == 1);
            send_pkt($urandom_range(1, 150), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 40) : -1, 1'b0);
        end
        rdy_mode = 0; gap_en = 0;
        drain();

        // Reset mid-packet with a pending word
        send_pkt(64, -1, 1'b0);
        send_beat(8'h5A, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mr_bus_en", bus_en, 1'b0);
        check("mr_bus_data", bus_data, 512'd0);
        check("mr_pkt_cnt", pkt_cnt, 16'd0);
        check("mr_st_ready", st_ready, 1'b1);
        q.delete(); cur.delete(); m_in_pkt = 0; m_pkt_cnt = 16'd0;
        m_err_sop = 1'b0; m_err_nosop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nosop_pulses = 0;
        send_beat(8'h33, 1'b0, 1'b1);
        send_pkt(5, -1, 1'b0);
        drain();
        check("mr_nosop", nosop_pulses, 1);
        check("mr_pkt_cnt_after", pkt_cnt, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/st2bus.md
Name: st2bus

Overview:
- Return-path packer for the NLB AFU turbo chain: turbo decoder output stream → st2bus → memory write bus.
- Collects ST-bit decoded beats framed by sop/eop, packs NUM_ST_PER_BUS beats LSB-first into one BUS-bit word and presents it with a valid/ready handshake.
- Partial final words are zero-padded and flagged with bus_last and a byte count.
- Single clock domain; sits on the turbo decoder clock.

Parameters:
- BUS, 512: output bus data width.
- ST, 8: input stream beat width (turbo source_data_s).
- NUM_ST_PER_BUS, 64: beats per bus word (BUS/ST).
- BW, 7: width of bus_bytes, equal to $clog2(NUM_ST_PER_BUS)+1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- st_data  in  ST  stream beat data.
- st_valid  in  1  beat valid.
- st_sop  in  1  first beat of packet.
- st_eop  in  1  last beat of packet.
- st_ready  out  1  block can accept a beat.
- bus_data  out  BUS  packed word.
- bus_en  out  1  bus_data valid.
- bus_ready  in  1  downstream accepts word.
- bus_last  out  1  word is last of packet.
- bus_bytes  out  BW  valid beats in word, range 1..NUM_ST_PER_BUS.
- pkt_cnt  out  16  completed packets, wraps at 65535→0.
- err_sop  out  1  one-cycle pulse: sop arrived mid-packet.
- err_nosop  out  1  one-cycle pulse: beat arrived outside a packet without sop.

Behaviour:
- Reset (async, rst_n=0):
  - bus_en=0, bus_data=0, bus_last=0, bus_bytes=0.
  - pkt_cnt=0, err_sop=0, err_nosop=0.
  - Pack index=0, state IDLE.
  - st_ready=1 (combinational).
- Transfers:
  - Input beat accepted when st_valid && st_ready.
  - Output word transferred when bus_en && bus_ready.
- st_ready = !bus_en || bus_ready (one-entry output register, combinational).
  - Full rate when bus_ready is held 1.
- Packing:
  - Accepted beat k of a word is written to pack register bits [k*ST +: ST]; k counts 0..NUM_ST_PER_BUS-1.
  - Unwritten bits are 0, and the pack register is cleared when a word is issued.
- Word issue:
  - A word is issued on the accepting beat that either fills index NUM_ST_PER_BUS-1 or carries eop.
  - On the next cycle (latency 1): bus_en=1, bus_data = packed word, bus_bytes = k+1, bus_last = eop of that beat.
  - bus_en, bus_data, bus_last and bus_bytes hold stable until bus_en && bus_ready.
  - bus_en drops the cycle after the transfer unless a new word is issued in the same cycle (back-to-back allowed).
- State machine:
  - IDLE: beat with sop → FILL and pack as beat 0. Beat without sop → discarded, err_nosop pulse next cycle, stay IDLE.
  - FILL: beats pack normally. Beat with eop → word issued, pkt_cnt incremented with that word, → IDLE.
  - sop+eop on the same beat in IDLE: one-beat packet, bus_bytes=1, bus_last=1, state stays IDLE.
  - sop in FILL: current partial word discarded (never issued), err_sop pulse, beat packed as beat 0 of a new packet, stay FILL.
- Word-boundary and exact-fill cases:
  - Packet of exactly M*NUM_ST_PER_BUS beats: final word has bus_bytes=NUM_ST_PER_BUS and bus_last=1.
  - No extra empty word is issued.
- st_sop/st_eop are ignored when st_valid=0.
- Reset mid-packet: all state cleared, pending output word dropped. The first beat after reset must carry sop, otherwise err_nosop.

Optional Feature:
- Macro: ST2BUS_STATUS_EN.
- When defined:
  - After the last data word of each packet, one extra status word is issued.
  - Data word has bus_last=0. Status word has bus_last=1, bus_bytes=0.
  - Status word bus_data[15:0] = packet beat count (saturating at 65535); [31:16] = pkt_cnt after increment; [32] = packet began after an err_sop restart; all other bits 0.
  - st_ready=0 while the status word is pending behind the data word. FSM gains state STAT between FILL and IDLE.
- When undefined:
  - No status word, no STAT state.
  - bus_last marks the final data word, as described above.

Test Plan:
- Reset, then 128 beats data=beat index (0..127), sop on beat 0, eop on beat 127, bus_ready=1 → two words; word0 bytes 0..63 LSB-first with bus_bytes=64, bus_last=0; word1 bytes 64..127 with bus_last=1; pkt_cnt=1; no beat stalled.
- 70-beat packet → word1 has bus_bytes=6, bits above 47 are zero, bus_last=1.
- bus_ready=0 for 10 cycles while a word is pending → st_ready=0 throughout, bus_data stable; releasing bus_ready gives transfer and resumed input.
- Beat without sop in IDLE → discarded, err_nosop pulses once; sop on beat 30 of a 40-beat run → err_sop pulses, first 30 beats never appear on the bus.
- Single beat with sop+eop=1, data 0xA5 → bus_data=0xA5, bus_bytes=1, bus_last=1.
- With ST2BUS_STATUS_EN defined, a 128-beat packet → three words; the third has bus_last=1 and status bits[15:0]=128, [31:16]=1.
